// File: rtl/bit64_adder_reg_pkg.sv
// Shared constants for the execute-stage ALU add datapath.
// The default data width is exported so other ALU blocks size their operands consistently.
package bit64_adder_reg_pkg;

  localparam int DEFAULT_WIDTH = 64;

endpackage : bit64_adder_reg_pkg

// File: rtl/bit64_adder_reg_full_adder.sv
// One-bit full adder cell; chained by the top level to form the ripple-carry sum.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Plain gate equations so X on any input reaches both outputs.
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/bit64_adder_reg.sv
// Registered two's-complement adder with signed-overflow flag (execute-stage ALU add path).
// Ripple-carry sum is formed combinationally and captured on the rising edge: one-cycle latency.
module bit64_adder_reg
  import bit64_adder_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    overflow
);

  logic        [WIDTH:0]   carry_p0;
  logic signed [WIDTH-1:0] sum_p0;
  logic                    ovf_p0;
  logic signed [WIDTH-1:0] sum_p1;
  logic                    ovf_p1;

  // ---- stage p0: combinational ripple-carry chain ----
  assign carry_p0[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry_p0[i]),
      .s    (sum_p0[i]),
      .cout (carry_p0[i+1])
    );
  end

  // Carry into the sign bit differing from carry out of it means the signed result wrapped.
  assign ovf_p0 = carry_p0[WIDTH-1] ^ carry_p0[WIDTH];

  // ---- stage p1: output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_p1 <= '0;
      ovf_p1 <= 1'b0;
    end else begin
      sum_p1 <= sum_p0;
      ovf_p1 <= ovf_p0;
    end
  end

  assign sum      = sum_p1;
  assign overflow = ovf_p1;

endmodule : bit64_adder_reg

// File: tb/tb_bit64_adder_reg.sv
// Scoreboard bench for bit64_adder_reg: stimulus queues expected results,
// a monitor compares them one edge later against the registered outputs.
module tb_bit64_adder_reg;

  localparam int W = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic signed [W-1:0] a;
  logic signed [W-1:0] b;
  logic signed [W-1:0] sum;
  logic                overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         o;
    string        name;
  } exp_t;

  exp_t q[$];

  bit64_adder_reg #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .sum      (sum),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference: exact signed sum in 65 bits; overflow when it does not fit in 64.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input string nm);
    exp_t e;
    logic signed [W:0] full;
    logic signed [W:0] maxv;
    logic signed [W:0] minv;
    full = $signed({x[W-1], x}) + $signed({y[W-1], y});
    maxv = (65'sd1 <<< (W-1)) - 65'sd1;
    minv = -(65'sd1 <<< (W-1));
    e.s = full[W-1:0];
    e.o = (full > maxv) || (full < minv);
    e.name = nm;
    return e;
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act_s, input logic act_o,
                       input logic [W-1:0] exp_s, input logic exp_o);
    checks++;
    if (act_s !== exp_s || act_o !== exp_o) begin
      errors++;
      $display("FAIL %s: got sum=%h ovf=%b, expected sum=%h ovf=%b", nm, act_s, act_o, exp_s, exp_o);
    end
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input string nm);
    @(negedge clk);
    a = x;
    b = y;
    q.push_back(model(x, y, nm));
  endtask

  // Monitor: every result is visible just after the capturing edge.
  always @(posedge clk) begin
    #1;
    if (!rst && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.name, sum, overflow, e.s, e.o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    a = 64'sd5;
    b = 64'sd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", sum, overflow, '0, 1'b0);

    // Release reset with 5+7 still on the inputs.
    rst = 1'b0;
    q.push_back(model(64'd5, 64'd7, "reset_release"));

    issue(64'd222222, 64'd11111111111, "mixed_mag");
    issue(64'd222222, 64'd1, "mixed_b1");
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, "pos_ovf");
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "neg_ovf_min_min");
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "neg_ovf_min_m1");
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "carry_no_ovf");
    issue(-64'sd5, -64'sd7, "neg_no_ovf");
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, "pos_ovf_max_max");

    // Random stream with asynchronous reset pulses between edges.
    for (int i = 0; i < 160; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if (i % 4 == 0) rb = {ra[W-1], rb[W-2:0]};
      issue(ra, rb, "random");
      if (i % 37 == 10) begin
        #2 rst = 1'b1;
        #1 check("async_reset_pulse", sum, overflow, '0, 1'b0);
        #1 rst = 1'b0;
      end
    end

    // Held reset across edges mid-stream drops the queued result.
    @(negedge clk);
    rst = 1'b1;
    #1 check("async_reset_held", sum, overflow, '0, 1'b0);
    q.delete();
    repeat (2) @(negedge clk);
    check("reset_held_edges", sum, overflow, '0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      issue(ra, rb, "random_after_reset");
    end

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bit64_adder_reg

// File: doc/bit64_adder_reg.md
Name: bit64_adder_reg

Overview:
Registered 64-bit two's-complement adder with a signed-overflow flag; this is the add datapath of the pipeline's execute-stage ALU. Operands are summed combinationally through a ripple-carry chain of 1-bit full adders. Sum and overflow are captured in output registers on the rising clock edge, giving a fixed one-cycle latency.

Parameters:
WIDTH, 64, operand and sum width in bits. Must be at least 2. All test values below assume 64.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous active-high reset
a  input  WIDTH  signed operand A (two's complement)
b  input  WIDTH  signed operand B (two's complement)
sum  output  WIDTH  registered a+b, modulo 2^WIDTH
overflow  output  1  registered signed-overflow flag for the same addition

Behaviour:
- Reset: asserting rst immediately forces sum=0 and overflow=0, without waiting for clk. Outputs hold 0 while rst is high. The first capture happens on the first rising clk edge after rst deasserts.
- Combinational core: c[0]=0. For each bit i: s[i] = a[i]^b[i]^c[i], and c[i+1] = majority(a[i], b[i], c[i]).
- Overflow rule: ovf = c[WIDTH-1] XOR c[WIDTH]. This equals (a,b signs equal) AND (s sign differs from the a,b sign).
- Carry-out c[WIDTH] is not exported.
- Register: on each rising clk edge with rst low, sum<=s and overflow<=ovf.
- Latency: operands present before edge N appear on the outputs immediately after edge N.
- No enable and no handshake. A new result is captured every cycle and outputs always reflect the last sampled operands.
- Wrap-around: the result is always truncated to WIDTH bits. On overflow the wrapped value is still output, not saturated.
- Reset mid-operation: any in-flight result is discarded and outputs go to 0.
- Unknown/X operands must not be masked; X propagates to the outputs.
- No latches. The only storage is the WIDTH+1 output flops.

Decomposition:
- No shared package is required.
- Optionally, a package constant for the default data width (64) can be shared with the rest of the ALU.
- One natural sub-module: full_adder (inputs a, b, cin; outputs s, cout), instantiated WIDTH times in a generate loop to form the ripple chain.
- The top level contains the generate loop, the overflow XOR and the output register process.

Test Plan:
- Reset: rst=1 with a=5, b=7 and clk toggling -> sum=0, overflow=0. Release rst; after the next edge -> sum=12, overflow=0.
- Mixed magnitudes: a=222222, b=11111111111 -> one edge later, sum=11111333333, overflow=0. Then change b to 1 -> next edge, sum=222223, overflow=0.
- Positive overflow: a=0x7FFFFFFFFFFFFFFF, b=1 -> sum=0x8000000000000000, overflow=1.
- Negative overflow: a=0x8000000000000000, b=0x8000000000000000 -> sum=0, overflow=1. Also a=0x8000000000000000, b=-1 -> sum=0x7FFFFFFFFFFFFFFF, overflow=1.
- No false overflow on carry-out: a=-1, b=1 -> sum=0, overflow=0. Also a=-5, b=-7 -> sum=-12, overflow=0.
- Async reset mid-stream: drive random operands each cycle and pulse rst between clock edges -> outputs drop to 0 immediately, not at the next edge. Afterwards, results match a 64-bit reference model each cycle with 1-cycle latency.
